// File: rtl/lib_voq_islip_alloc_if.sv
// lib_voq_islip_alloc_if: request/enable inputs and match outputs of the iSLIP VOQ allocator
interface lib_voq_islip_alloc_if #(parameter int N = 4, parameter int M = 4);
  logic ce;
  logic [0:N-1][0:M-1] req;
  logic [0:M-1] out_en;
  logic [0:N-1][0:M-1] grant;
  logic [0:M-1][0:N-1] sel;
  logic [0:M-1] out_val;
  modport master (output ce, req, out_en, input grant, sel, out_val);
  modport slave (input ce, req, out_en, output grant, sel, out_val);
endinterface

// File: rtl/lib_voq_islip_alloc.sv
// lib_voq_islip_alloc: zero-latency iSLIP allocator for an NxM VOQ crossbar
// Define LIB_VOQ_ISLIP_TWO_ITER_EN to add a second, pointer-neutral match iteration.
module lib_voq_islip_alloc #(parameter int N = 4, parameter int M = 4) (
  input logic clk,
  input logic reset_n,
  lib_voq_islip_alloc_if.slave bus
);
  localparam int NW = $clog2(N);
  localparam int MW = $clog2(M);
  typedef logic [0:N-1][0:M-1] mat_t;
  typedef logic [M-1:0][NW-1:0] gp_t;
  typedef logic [N-1:0][MW-1:0] ap_t;
  gp_t g_ptr;
  ap_t a_ptr;
  mat_t elig, acc1, acc;
`ifdef LIB_VOQ_ISLIP_TWO_ITER_EN
  mat_t busy;
  logic [0:M-1] taken;
`endif
  function automatic mat_t islip(mat_t e, gp_t gp, ap_t ap);
    mat_t g, a;
    int x;
    logic hit;
    g = '0;
    a = '0;
    for (int j = 0; j < M; j++) begin
      hit = 1'b0;
      for (int k = 0; k < N; k++) begin
        x = (int'(gp[j]) + k) % N;
        if (!hit && e[x][j]) begin
          g[x][j] = 1'b1;
          hit = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      hit = 1'b0;
      for (int k = 0; k < M; k++) begin
        x = (int'(ap[i]) + k) % M;
        if (!hit && g[i][x]) begin
          a[i][x] = 1'b1;
          hit = 1'b1;
        end
      end
    end
    return a;
  endfunction
  always_comb begin
    elig = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        elig[i][j] = bus.req[i][j] & bus.out_en[j] & bus.ce & reset_n;
    acc1 = islip(elig, g_ptr, a_ptr);
`ifdef LIB_VOQ_ISLIP_TWO_ITER_EN
    taken = '0;
    busy = '0;
    for (int i = 0; i < N; i++) taken = taken | acc1[i];
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        busy[i][j] = (|acc1[i]) | taken[j];
    acc = acc1 | islip(elig & ~busy, g_ptr, a_ptr);
`else
    acc = acc1;
`endif
    bus.grant = acc;
    bus.sel = '0;
    bus.out_val = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) begin
        bus.sel[j][i] = acc[i][j];
        bus.out_val[j] = bus.out_val[j] | acc[i][j];
      end
  end
  // only first-iteration accepts move pointers; that keeps the pointers desynchronised
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      g_ptr <= '0;
      a_ptr <= '0;
    end else begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < M; j++)
          if (acc1[i][j]) begin
            g_ptr[j] <= NW'((i + 1) % N);
            a_ptr[i] <= MW'((j + 1) % M);
          end
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        assert ($onehot0(bus.grant[i]));
        for (int j = 0; j < M; j++) assert (!bus.grant[i][j] || bus.req[i][j]);
      end
      for (int j = 0; j < M; j++) assert ($onehot0(bus.sel[j]));
    end
  end
`endif
endmodule

// File: tb/tb_lib_voq_islip_alloc.sv
// tb_lib_voq_islip_alloc: directed scoreboard bench for the 4x4 iSLIP allocator
module tb_lib_voq_islip_alloc;
  typedef logic [0:3][0:3] mat_t;
  typedef struct { string nm; mat_t g; } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  lib_voq_islip_alloc_if #(.N(4), .M(4)) bus ();
  lib_voq_islip_alloc #(.N(4), .M(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(string nm, logic [15:0] act, logic [15:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      mat_t s;
      logic [0:3] v;
      e = q.pop_front();
      s = '0;
      v = '0;
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) begin
          s[j][i] = e.g[i][j];
          v[j] = v[j] | e.g[i][j];
        end
      check({e.nm, ".grant"}, bus.grant, e.g);
      check({e.nm, ".sel"}, bus.sel, s);
      check({e.nm, ".out_val"}, {12'b0, bus.out_val}, {12'b0, v});
    end
  end
  task automatic cyc(string nm, mat_t g);
    exp_t e;
    e.nm = nm;
    e.g = g;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  // all-request pattern after reset: cycle c matches input i to output (c-i) mod 4 for i <= c
  function automatic mat_t diag(int c);
    mat_t m;
    logic [0:3] r;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (i <= c) begin
        r = 4'b1000;
        m[i] = r >> ((c - i) % 4);
      end
    return m;
  endfunction
  function automatic mat_t row(int i, logic [0:3] r);
    mat_t m;
    m = '0;
    m[i] = r;
    return m;
  endfunction
  task automatic do_reset;
    reset_n = 1'b0;
    bus.ce = 1'b1;
    bus.req = '0;
    bus.out_en = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish before 100000");
    $fatal(1);
  end
  initial begin
    do_reset;
    bus.req = '1;
    bus.out_en = '1;
    for (int c = 0; c < 8; c++) cyc($sformatf("s1_c%0d", c), diag(c));
    do_reset;
    bus.out_en = '1;
    bus.req[2][3] = 1'b1;
    repeat (3) cyc("s2_single", row(2, 4'b0001));
    bus.req = '0;
    for (int i = 0; i < 4; i++) bus.req[i][3] = 1'b1;
    cyc("s2_gptr3", row(3, 4'b0001));
    cyc("s2_gptr_wrap", row(0, 4'b0001));
    bus.req = '0;
    bus.req[2] = 4'b1111;
    cyc("s2_aptr0", row(2, 4'b1000));
    do_reset;
    for (int i = 0; i < 4; i++) bus.req[i] = 4'b0100;
    bus.out_en = 4'b1011;
    repeat (2) cyc("s3_blocked", '0);
    bus.out_en = '1;
    for (int k = 0; k < 5; k++) cyc($sformatf("s3_rr%0d", k), row(k % 4, 4'b0100));
    do_reset;
    bus.req = '1;
    bus.out_en = '1;
    cyc("s4_c0", diag(0));
    cyc("s4_c1", diag(1));
    bus.ce = 1'b0;
    repeat (2) cyc("s4_stall", '0);
    bus.ce = 1'b1;
    cyc("s4_c2", diag(2));
    cyc("s4_c3", diag(3));
    do_reset;
    bus.req = '1;
    bus.out_en = '1;
    for (int c = 0; c < 5; c++) cyc($sformatf("s5_pre%0d", c), diag(c));
    reset_n = 1'b0;
    #1;
    check("s5_immediate", bus.grant, '0);
    cyc("s5_in_reset", '0);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) cyc($sformatf("s5_post%0d", c), diag(c));
    do_reset;
    bus.out_en = '1;
    bus.req[0] = 4'b1100;
    bus.req[1] = 4'b1100;
`ifdef LIB_VOQ_ISLIP_TWO_ITER_EN
    cyc("s6_iter", row(0, 4'b1000) | row(1, 4'b0100));
`else
    cyc("s6_iter", row(0, 4'b1000));
`endif
    bus.req = '0;
    bus.req[1] = 4'b0100;
    bus.req[2] = 4'b0100;
    cyc("s6_gptr1_hold", row(1, 4'b0100));
    repeat (2) @(negedge clk);
    check("drain", 16'(q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
